// File: rtl/i2c_byte_master.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : i2c_byte_master
//  Purpose  : Byte-level I2C master (START / WRITE / READ / STOP commands)
//             driving open-drain SCL/SDA pull-low enables, with slave clock
//             stretching and a stretch timeout.
//  Revision : 1.0 - initial release
// ============================================================================
module i2c_byte_master #(
    parameter int CLK_DIV         = 62,
    parameter int STRETCH_TIMEOUT = 65535
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       cmd_valid_i,
    output logic       cmd_ready_o,
    input  logic [1:0] cmd_op_i,
    input  logic [7:0] cmd_wdata_i,
    input  logic       cmd_rd_nack_i,
    output logic       rsp_valid_o,
    output logic [7:0] rsp_rdata_o,
    output logic       rsp_nack_o,
    output logic       rsp_timeout_o,
    output logic       busy_o,
    input  logic       scl_in_i,
    input  logic       sda_in_i,
    output logic       scl_drive_low_o,
    output logic       sda_drive_low_o
);

    localparam int CW = $clog2(CLK_DIV + 2);
    localparam int SW = $clog2(STRETCH_TIMEOUT + 1);

    localparam logic [1:0] OP_START = 2'd0;
    localparam logic [1:0] OP_WRITE = 2'd1;
    localparam logic [1:0] OP_READ  = 2'd2;
    localparam logic [1:0] OP_STOP  = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_BIT   = 3'd2,
        S_STOP  = 3'd3,
        S_RESP  = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [1:0]      phase_q, phase_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [SW-1:0]   stretch_q, stretch_d;
    logic [3:0]      bcnt_q, bcnt_d;      // 0..7 data bits (MSB first), 8 = ACK
    logic [7:0]      sh_q, sh_d;          // tx bits out of [7] / rx bits into [0]
    logic [1:0]      op_q, op_d;
    logic            rdnack_q, rdnack_d;
    logic            ack_q, ack_d;        // SDA level sampled in the ACK bit
    logic            scl_q, scl_d;        // last driven line values, held between ops
    logic            sda_q, sda_d;
    logic [7:0]      rdata_q, rdata_d;
    logic            nack_q, nack_d;
    logic            to_q, to_d;

    logic            w_active;
    logic            w_tick;
    logic            w_stall;
    logic            w_bit_low;

    assign w_active = (state_q == S_START) || (state_q == S_BIT) || (state_q == S_STOP);
    assign w_tick   = (cnt_q == CW'(CLK_DIV));
    // Phase 1 always releases SCL; a low level there means a slave is stretching.
    assign w_stall  = (phase_q == 2'd1) && !scl_in_i;

    // SDA pull-low for the current bit: data bits for WRITE, master ACK/NACK for READ
    always_comb begin
        w_bit_low = 1'b0;
        if (bcnt_q == 4'd8) begin
            w_bit_low = (op_q == OP_READ) ? ~rdnack_q : 1'b0;
        end else begin
            w_bit_low = (op_q == OP_WRITE) ? ~sh_q[7] : 1'b0;
        end
    end

    assign rsp_rdata_o   = rdata_q;
    assign rsp_nack_o    = nack_q;
    assign rsp_timeout_o = to_q;

    // Next-state, line drive and handshake logic
    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        cnt_d     = cnt_q;
        stretch_d = stretch_q;
        bcnt_d    = bcnt_q;
        sh_d      = sh_q;
        op_d      = op_q;
        rdnack_d  = rdnack_q;
        ack_d     = ack_q;
        rdata_d   = rdata_q;
        nack_d    = nack_q;
        to_d      = to_q;
        scl_drive_low_o = scl_q;
        sda_drive_low_o = sda_q;
        cmd_ready_o = 1'b0;
        busy_o      = w_active;
        rsp_valid_o = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                cmd_ready_o = 1'b1;
                if (cmd_valid_i) begin
                    op_d      = cmd_op_i;
                    sh_d      = cmd_wdata_i;
                    rdnack_d  = cmd_rd_nack_i;
                    phase_d   = 2'd0;
                    cnt_d     = '0;
                    stretch_d = '0;
                    bcnt_d    = 4'd0;
                    case (cmd_op_i)
                        OP_START: state_d = S_START;
                        OP_STOP:  state_d = S_STOP;
                        default:  state_d = S_BIT;
                    endcase
                end
            end
            S_START: begin
                // p0 keeps SCL as it was so a repeated start does not glitch SCL
                case (phase_q)
                    2'd0:    sda_drive_low_o = 1'b0;
                    2'd1:    begin scl_drive_low_o = 1'b0; sda_drive_low_o = 1'b0; end
                    2'd2:    begin scl_drive_low_o = 1'b0; sda_drive_low_o = 1'b1; end
                    default: begin scl_drive_low_o = 1'b1; sda_drive_low_o = 1'b1; end
                endcase
            end
            S_BIT: begin
                scl_drive_low_o = (phase_q == 2'd0) || (phase_q == 2'd3);
                sda_drive_low_o = w_bit_low;
            end
            S_STOP: begin
                case (phase_q)
                    2'd0:    begin scl_drive_low_o = 1'b1; sda_drive_low_o = 1'b1; end
                    2'd1:    begin scl_drive_low_o = 1'b0; sda_drive_low_o = 1'b1; end
                    default: begin scl_drive_low_o = 1'b0; sda_drive_low_o = 1'b0; end
                endcase
            end
            S_RESP: begin
                rsp_valid_o = 1'b1;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        scl_d = scl_drive_low_o;
        sda_d = sda_drive_low_o;

        if (w_active) begin
            if (w_stall) begin
                if (stretch_q == SW'(STRETCH_TIMEOUT - 1)) begin
                    // Abort: free the bus and report the timeout
                    state_d = S_RESP;
                    to_d    = 1'b1;
                    nack_d  = 1'b0;
                    scl_d   = 1'b0;
                    sda_d   = 1'b0;
                end else begin
                    stretch_d = stretch_q + SW'(1);
                end
            end else begin
                stretch_d = '0;
                if (w_tick) begin
                    cnt_d = '0;
                    // Sample SDA on the last cycle of the SCL-high phase
                    if ((state_q == S_BIT) && (phase_q == 2'd2)) begin
                        if (bcnt_q == 4'd8) begin
                            ack_d = sda_in_i;
                        end else if (op_q == OP_READ) begin
                            sh_d = {sh_q[6:0], sda_in_i};
                        end
                    end
                    if (phase_q != 2'd3) begin
                        phase_d = phase_q + 2'd1;
                    end else begin
                        phase_d = 2'd0;
                        if ((state_q == S_BIT) && (bcnt_q != 4'd8)) begin
                            bcnt_d = bcnt_q + 4'd1;
                            if (op_q == OP_WRITE) begin
                                sh_d = {sh_q[6:0], 1'b0};
                            end
                        end else begin
                            state_d = S_RESP;
                            to_d    = 1'b0;
                            nack_d  = (state_q == S_BIT) && (op_q == OP_WRITE) && ack_q;
                            if ((state_q == S_BIT) && (op_q == OP_READ)) begin
                                rdata_d = sh_q;
                            end
                        end
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
        end
    end

    // State and datapath registers; reset frees both lines at once
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= S_IDLE;
            phase_q   <= 2'd0;
            cnt_q     <= '0;
            stretch_q <= '0;
            bcnt_q    <= 4'd0;
            sh_q      <= 8'd0;
            op_q      <= 2'd0;
            rdnack_q  <= 1'b0;
            ack_q     <= 1'b0;
            scl_q     <= 1'b0;
            sda_q     <= 1'b0;
            rdata_q   <= 8'd0;
            nack_q    <= 1'b0;
            to_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            cnt_q     <= cnt_d;
            stretch_q <= stretch_d;
            bcnt_q    <= bcnt_d;
            sh_q      <= sh_d;
            op_q      <= op_d;
            rdnack_q  <= rdnack_d;
            ack_q     <= ack_d;
            scl_q     <= scl_d;
            sda_q     <= sda_d;
            rdata_q   <= rdata_d;
            nack_q    <= nack_d;
            to_q      <= to_d;
        end
    end

endmodule
`default_nettype wire
